p_mac_pipe: RTL and testbench

//  Parametrised pipelined multiply-accumulate unit for the datapath's dot-product/filter lanes.

---
 rtl/p_mult_pkg.sv | 31 +++
 rtl/p_mult_stage.sv | 27 ++
 rtl/p_mac_pipe.sv | 106 ++++++++++
 tb/tb_p_mac_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_mult_pkg.sv
// p_mult_pkg: shared constants, stage sideband and the accumulate
// overflow rule for the pipelined multiply-accumulate unit.
package p_mult_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int LAT_DEF   = 3;
    localparam int ACC_DEF   = 20;

    typedef struct packed {
        logic valid;
        logic sgn;
        logic clr;
    } side_t;

    // Signed: like-signed addends yielding an unlike sign. Unsigned: carry out.
    function automatic logic add_ovf(
        input logic sgn,
        input logic a_msb,
        input logic b_msb,
        input logic s_msb,
        input logic carry
    );
        logic r;
        if (sgn)
            r = (a_msb == b_msb) && (s_msb != a_msb);
        else
            r = carry;
        return r;
    endfunction

endpackage

// File: rtl/p_mult_stage.sv
// p_mult_stage: one enable-gated product register stage carrying
// data plus its sideband, cleared asynchronously.
module p_mult_stage
    import p_mult_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [DW-1:0] d,
    input  side_t         sd,
    output logic [DW-1:0] q,
    output side_t         sq
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q  <= '0;
            sq <= '0;
        end else if (en) begin
            q  <= d;
            sq <= sd;
        end
    end

endmodule

// File: rtl/p_mac_pipe.sv
// p_mac_pipe: pipelined signed/unsigned multiply-accumulate with a
// valid/ready handshake and a single global stall.
module p_mac_pipe
    import p_mult_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int MULT_LATENCY = LAT_DEF,
    parameter int ACC_WIDTH    = ACC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    input  logic                 in_signed,
    input  logic                 in_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] res,
    output logic                 res_ovf
);

    localparam int PW = 2 * WIDTH;
    localparam logic [ACC_WIDTH-1:0] HI_MASK =
        ~((ACC_WIDTH'(1) << PW) - ACC_WIDTH'(1));

    logic adv;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    side_t            s0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a0 <= '0;
            b0 <= '0;
            s0 <= '0;
        end else if (adv) begin
            a0 <= dataa;
            b0 <= datab;
            s0 <= '{valid: in_valid, sgn: in_signed, clr: in_clr};
        end
    end

    // Extending to 2*WIDTH and keeping the low half is exact for both modes.
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    logic [PW-1:0] prod;

    assign ax   = {{WIDTH{s0.sgn & a0[WIDTH-1]}}, a0};
    assign bx   = {{WIDTH{s0.sgn & b0[WIDTH-1]}}, b0};
    assign prod = ax * bx;

    logic [PW-1:0] pd [MULT_LATENCY+1];
    side_t         ps [MULT_LATENCY+1];

    assign pd[0] = prod;
    assign ps[0] = s0;

    for (genvar i = 0; i < MULT_LATENCY; i++) begin : g_prod
        p_mult_stage #(
            .DW(PW)
        ) u_stage (
            .clk  (clk),
            .reset(reset),
            .en   (adv),
            .d    (pd[i]),
            .sd   (ps[i]),
            .q    (pd[i+1]),
            .sq   (ps[i+1])
        );
    end

    logic [PW-1:0]        pl;
    side_t                sl;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf;

    assign pl  = pd[MULT_LATENCY];
    assign sl  = ps[MULT_LATENCY];
    assign ext = ACC_WIDTH'(pl)
               | ((sl.sgn && pl[PW-1]) ? HI_MASK : '0);
    assign sum = {1'b0, res} + {1'b0, ext};
    assign ovf = add_ovf(sl.sgn, res[ACC_WIDTH-1], ext[ACC_WIDTH-1],
                         sum[ACC_WIDTH-1], sum[ACC_WIDTH]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            res       <= '0;
            res_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= sl.valid;
            if (sl.valid) begin
                res     <= sl.clr ? ext : sum[ACC_WIDTH-1:0];
                res_ovf <= !sl.clr && ovf;
            end
        end
    end

endmodule

// File: tb/tb_p_mac_pipe.sv
// tb_p_mac_pipe: randomized scoreboard bench for p_mac_pipe checked
// against an arithmetic reference accumulator.
module tb_p_mac_pipe;

    localparam int W  = 8;
    localparam int L  = 3;
    localparam int AW = 20;
    localparam longint M = 64'd1 << AW;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  dataa     = '0;
    logic [W-1:0]  datab     = '0;
    logic          in_signed = 1'b0;
    logic          in_clr    = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] res;
    logic          res_ovf;

    always #5 clk = ~clk;

    p_mac_pipe #(
        .WIDTH       (W),
        .MULT_LATENCY(L),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dataa    (dataa),
        .datab    (datab),
        .in_signed(in_signed),
        .in_clr   (in_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res      (res),
        .res_ovf  (res_ovf)
    );

    typedef struct {
        longint r;
        logic   o;
        int     cyc;
        int     st;
    } exp_t;

    exp_t          q[$];
    int            nvec  = 0;
    int            nerr  = 0;
    int            cyc   = 0;
    int            stcnt = 0;
    int            nout  = 0;
    int            novf  = 0;
    int            rmode = 0;
    longint        macc  = 0;
    logic [AW-1:0] last_res = '0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_res = '0;
    logic          prev_ovf = 1'b0;

    task automatic check(input string name, input longint act,
                         input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Reference: true product, wrapped into AW bits; overflow judged
    // on the mathematical sum rather than on bit patterns.
    function automatic void model(input logic [W-1:0] a, b,
                                  input logic s, c,
                                  output longint r, output logic o);
        longint p, pe, sa, sp, tot;
        if (s)
            p = longint'($signed(a)) * longint'($signed(b));
        else
            p = longint'(a) * longint'(b);
        pe = ((p % M) + M) % M;
        if (c) begin
            r = pe;
            o = 1'b0;
        end else if (s) begin
            sa  = (macc >= M / 2) ? macc - M : macc;
            sp  = (pe >= M / 2) ? pe - M : pe;
            tot = sa + sp;
            o   = (tot >= M / 2) || (tot < -(M / 2));
            r   = (macc + pe) % M;
        end else begin
            tot = macc + pe;
            o   = tot >= M;
            r   = tot % M;
        end
        macc = r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic stall;
        cyc++;
        if (!reset) begin
            q.delete();
            macc       = 0;
            prev_stall = 1'b0;
            check("reset_out_valid", out_valid, 0);
            check("reset_res", res, 0);
        end else begin
            stall = out_valid && !out_ready;
            check("in_ready", in_ready, !stall);
            if (prev_stall) begin
                check("hold_res", res, prev_res);
                check("hold_ovf", res_ovf, prev_ovf);
                check("hold_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = q.pop_front();
                    check("res", res, e.r);
                    check("res_ovf", res_ovf, e.o);
                    check("latency", cyc, e.cyc + L + 2 + (stcnt - e.st));
                    last_res = res;
                    nout++;
                    if (res_ovf) novf++;
                end
            end
            if (stall) stcnt++;
            if (in_valid && in_ready) begin
                model(dataa, datab, in_signed, in_clr, e.r, e.o);
                e.cyc = cyc;
                e.st  = stcnt;
                q.push_back(e);
            end
            prev_stall = stall;
            prev_res   = res;
            prev_ovf   = res_ovf;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic send(input logic [W-1:0] a, b, input logic s, c);
        int n = 0;
        dataa     = a;
        datab     = b;
        in_signed = s;
        in_clr    = c;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("send_timeout");
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dataa     = W'($urandom);
        datab     = W'($urandom);
        in_signed = 1'($urandom);
        in_clr    = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        rmode = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_valid", out_valid, 0);
        check("post_reset_res", res, 0);
        check("post_reset_ovf", res_ovf, 0);
        @(posedge clk);
        #1;

        send(8'd3, 8'd4, 1'b0, 1'b1);
        drain();
        check("t1_res", last_res, 12);

        send(8'hFE, 8'd5, 1'b1, 1'b1);
        send(8'd7, 8'hFD, 1'b1, 1'b0);
        send(8'h80, 8'h80, 1'b1, 1'b0);
        drain();
        check("t2_res", last_res, 16353);

        // Seventeen 255*255 beats are needed to pass 2^20.
        novf = 0;
        send(8'd255, 8'd255, 1'b0, 1'b1);
        repeat (16) send(8'd255, 8'd255, 1'b0, 1'b0);
        drain();
        check("t3_res", last_res, 17 * 65025 - M);
        check("t3_ovf_count", novf, 1);

        rmode = 1;
        nout  = 0;
        for (int i = 1; i <= 8; i++)
            send(W'(i), 8'd1, 1'b0, i == 1);
        drain();
        check("t4_res", last_res, 36);
        check("t4_count", nout, 8);

        send(8'd10, 8'd1, 1'b0, 1'b1);
        idle(20);
        send(8'd5, 8'd1, 1'b0, 1'b0);
        drain();
        check("t5_res", last_res, 15);

        send(8'd1, 8'd1, 1'b0, 1'b1);
        send(8'd2, 8'd3, 1'b0, 1'b0);
        send(8'd4, 8'd4, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("t6_async_flush", out_valid, 0);
        idle(2);
        reset = 1'b1;
        idle(8);
        send(8'd2, 8'd2, 1'b0, 1'b0);
        drain();
        check("t6_res", last_res, 4);

        rmode = 2;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(W'($urandom), W'($urandom), 1'($urandom),
                 $urandom_range(0, 7) == 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
